aq_lsu_stream_wmerge: RTL and testbench

- Consumes the write-allocate-disable indication produced by the LSU store-stream detector.
- While that indication is high, store misses are not allocated. Instead they are accepted here and merged into a single 64-byte line buffer.
- The buffer is drained to the bus as one line-aligned write burst of 4 x 128-bit beats with byte strobes.
- Sits between the DCache store path and the bus write interface, beside the write-back path.

---
 rtl/aq_lsu_stream_wmerge_if.sv | 25 ++
 rtl/aq_lsu_stream_wmerge.sv | 147 ++++++++++++++
 tb/tb_aq_lsu_stream_wmerge.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aq_lsu_stream_wmerge_if.sv
// Line write channel from the stream write-merge buffer to the bus: address request, data beats, response.
// Handshake: a transfer happens in a cycle where req/vld and grnt/rdy are both high; req/vld and payload hold until then.
interface aq_lsu_stream_wmerge_if #(parameter int PADDR = 40);
  logic             smg_bus_aw_req;
  logic [PADDR-1:0] smg_bus_aw_addr;
  logic             bus_smg_aw_grnt;
  logic             smg_bus_w_vld;
  logic [127:0]     smg_bus_w_data;
  logic [15:0]      smg_bus_w_strb;
  logic             smg_bus_w_last;
  logic             bus_smg_w_rdy;
  logic             bus_smg_b_vld;

  modport master (
    output smg_bus_aw_req, smg_bus_aw_addr, smg_bus_w_vld, smg_bus_w_data,
           smg_bus_w_strb, smg_bus_w_last,
    input  bus_smg_aw_grnt, bus_smg_w_rdy, bus_smg_b_vld
  );

  modport slave (
    input  smg_bus_aw_req, smg_bus_aw_addr, smg_bus_w_vld, smg_bus_w_data,
           smg_bus_w_strb, smg_bus_w_last,
    output bus_smg_aw_grnt, bus_smg_w_rdy, bus_smg_b_vld
  );
endinterface

// File: rtl/aq_lsu_stream_wmerge.sv
// Stream-mode store merge: non-allocating store misses are merged into one 64-byte line
// and drained as a single 4 x 128-bit write burst with byte strobes.
module aq_lsu_stream_wmerge #(
  parameter int PADDR   = 40,
  parameter int TIMEOUT = 16
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  cp0_lsu_sync_req,
  input  logic                  amr_smg_wa_dis,
  input  logic                  dc_smg_st_req,
  input  logic [PADDR-1:0]      dc_smg_st_addr,
  input  logic [63:0]           dc_smg_st_data,
  input  logic [7:0]            dc_smg_st_be,
  output logic                  smg_dc_st_grnt,
  output logic                  smg_lsu_idle,
  output logic [2:0]            smg_dbg_state,
  aq_lsu_stream_wmerge_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MERGE = 3'd1,
    S_AW    = 3'd2,
    S_W     = 3'd3,
    S_B     = 3'd4
  } state_e;

  localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [PADDR-7:0] line_addr_q;
  logic [511:0]     buf_q;
  logic [63:0]      mask_q, mask_d;
  logic [1:0]       beat_q, beat_d;
  logic [5:0]       tmo_q, tmo_d;

  logic             same_line;
  logic             grant;
  logic             drain;
  logic [63:0]      merge_be;
  logic [511:0]     merge_bits;
  logic [511:0]     merge_data;
  logic [63:0]      mask_merged;
  logic             aw_req, w_vld, w_last;
  logic             unused_addr_lo;

  assign unused_addr_lo = ^dc_smg_st_addr[2:0];

  assign same_line = (dc_smg_st_addr[PADDR-1:6] == line_addr_q);
  assign grant     = dc_smg_st_req & amr_smg_wa_dis & ~cp0_lsu_sync_req &
                     ((state_q == S_IDLE) | ((state_q == S_MERGE) & same_line));

  // Doubleword lanes line up with the line layout, so replicating the data places every lane.
  assign merge_data = {8{dc_smg_st_data}};

  always_comb begin
    merge_be = 64'(dc_smg_st_be) << {dc_smg_st_addr[5:3], 3'b000};
    for (int i = 0; i < 64; i++) begin
      merge_bits[i*8 +: 8] = {8{merge_be[i]}};
    end
  end

  // A fresh line starts from an empty mask; the merge of this cycle is already included.
  assign mask_merged = ((state_q == S_IDLE) ? 64'd0 : mask_q) | (grant ? merge_be : 64'd0);

  assign drain = (&mask_merged) | (dc_smg_st_req & ~same_line) | ~amr_smg_wa_dis |
                 cp0_lsu_sync_req | (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    aw_req  = 1'b0;
    w_vld   = 1'b0;
    w_last  = 1'b0;
    if (grant) begin
      mask_d = mask_merged;
      tmo_d  = 6'd0;
    end
    case (state_q)
      S_IDLE: begin
        if (grant) state_d = S_MERGE;
      end
      S_MERGE: begin
        if (!grant) tmo_d = tmo_q + 6'd1;
        if (drain)  state_d = S_AW;
      end
      S_AW: begin
        aw_req = 1'b1;
        if (bus.bus_smg_aw_grnt) begin
          state_d = S_W;
          beat_d  = 2'd0;
        end
      end
      S_W: begin
        w_vld  = 1'b1;
        w_last = (beat_q == 2'd3);
        if (bus.bus_smg_w_rdy) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = S_B;
        end
      end
      S_B: begin
        if (bus.bus_smg_b_vld) begin
          state_d = S_IDLE;
          mask_d  = 64'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= S_IDLE;
      mask_q  <= 64'd0;
      beat_q  <= 2'd0;
      tmo_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
    end
  end

  // Payload storage is qualified by the byte mask, so it needs no reset.
  always_ff @(posedge forever_cpuclk) begin
    if (grant) begin
      buf_q <= (buf_q & ~merge_bits) | (merge_data & merge_bits);
      if (state_q == S_IDLE) line_addr_q <= dc_smg_st_addr[PADDR-1:6];
    end
  end

  assign smg_dc_st_grnt      = grant;
  assign smg_lsu_idle        = (state_q == S_IDLE);
  assign smg_dbg_state       = state_q;
  assign bus.smg_bus_aw_req  = aw_req;
  assign bus.smg_bus_aw_addr = {line_addr_q, 6'b000000};
  assign bus.smg_bus_w_vld   = w_vld;
  assign bus.smg_bus_w_data  = buf_q[{beat_q, 7'd0} +: 128];
  assign bus.smg_bus_w_strb  = mask_q[{beat_q, 4'd0} +: 16];
  assign bus.smg_bus_w_last  = w_last;

endmodule

// File: tb/tb_aq_lsu_stream_wmerge.sv
// Bench for the stream write-merge buffer: byte-array line model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_aq_lsu_stream_wmerge;
  localparam int PADDR   = 40;
  localparam int TIMEOUT = 16;
  localparam int P_IDLE = 0, P_MERGE = 1, P_AW = 2, P_W = 3, P_B = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             sync, wa_dis, st_req;
  logic [PADDR-1:0] st_addr;
  logic [63:0]      st_data;
  logic [7:0]       st_be;
  logic             grnt, idle;
  logic [2:0]       dbg_state;

  aq_lsu_stream_wmerge_if #(.PADDR(PADDR)) bus ();

  aq_lsu_stream_wmerge #(.PADDR(PADDR), .TIMEOUT(TIMEOUT)) dut (
    .forever_cpuclk   (clk),
    .cpurst_b         (rst_n),
    .cp0_lsu_sync_req (sync),
    .amr_smg_wa_dis   (wa_dis),
    .dc_smg_st_req    (st_req),
    .dc_smg_st_addr   (st_addr),
    .dc_smg_st_data   (st_data),
    .dc_smg_st_be     (st_be),
    .smg_dc_st_grnt   (grnt),
    .smg_lsu_idle     (idle),
    .smg_dbg_state    (dbg_state),
    .bus              (bus)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [15:0]  exp_q[$];
  logic [39:0]  got_aw[$];
  logic [127:0] got_data[$];
  logic [15:0]  got_strb[$];
  logic         got_last[$];
  int bursts = 0, wcyc = 0, aw_cyc = 0, last_grant_cyc = 0;
  bit aw_prev = 0, b_pending = 0;
  int resp_beat = 0, stall_beat = -1, stall_left = 0, aw_age = 0, b_age = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] dat(input int i);
    return (i < got_data.size()) ? got_data[i] : 'x;
  endfunction
  function automatic logic [39:0] awa(input int i);
    return (i < got_aw.size()) ? got_aw[i] : 'x;
  endfunction
  function automatic logic lst(input int i);
    return (i < got_last.size()) ? got_last[i] : 1'bx;
  endfunction

  // ---------------- line model, checked every cycle ----------------
  int          m_st = P_IDLE;
  logic [33:0] m_line = '0;
  logic [7:0]  m_buf[64];
  bit          m_mask[64];
  int          m_beat = 0, m_quiet = 0;

  always @(negedge clk) begin : compare
    logic         e_grnt, full, drain;
    logic [127:0] e_data;
    logic [15:0]  e_strb;
    int           q_old, idx;
    if (!rst_n) begin
      m_st = P_IDLE; m_beat = 0; m_quiet = 0;
      for (int i = 0; i < 64; i++) m_mask[i] = 1'b0;
      chk("rst_idle", idle, 1'b1);
      chk("rst_grnt", grnt, 1'b0);
      chk("rst_aw_req", bus.smg_bus_aw_req, 1'b0);
      chk("rst_w_vld", bus.smg_bus_w_vld, 1'b0);
      chk("rst_w_last", bus.smg_bus_w_last, 1'b0);
    end else begin
      e_grnt = st_req && wa_dis && !sync &&
               (m_st == P_IDLE || (m_st == P_MERGE && st_addr[39:6] == m_line));
      chk("grnt", grnt, e_grnt);
      chk("idle", idle, m_st == P_IDLE);
      chk("aw_req", bus.smg_bus_aw_req, m_st == P_AW);
      chk("w_vld", bus.smg_bus_w_vld, m_st == P_W);
      if (m_st == P_AW) chk("aw_addr", bus.smg_bus_aw_addr, {m_line, 6'b0});
      if (m_st == P_W) begin
        for (int b = 0; b < 16; b++) begin
          e_data[b*8 +: 8] = m_buf[m_beat*16 + b];
          e_strb[b]        = m_mask[m_beat*16 + b];
        end
        chk("w_strb", bus.smg_bus_w_strb, e_strb);
        chk("w_last", bus.smg_bus_w_last, m_beat == 3);
        // Only bytes with a strobe carry defined data.
        for (int b = 0; b < 16; b++)
          if (!e_strb[b]) e_data[b*8 +: 8] = bus.smg_bus_w_data[b*8 +: 8];
        chk("w_data", bus.smg_bus_w_data, e_data);
      end
      // advance the model by one clock
      q_old = m_quiet;
      if (e_grnt) begin
        if (m_st == P_IDLE) begin
          m_line = st_addr[39:6];
          for (int i = 0; i < 64; i++) m_mask[i] = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
          if (st_be[i]) begin
            idx = int'(st_addr[5:3]) * 8 + i;
            m_buf[idx]  = st_data[i*8 +: 8];
            m_mask[idx] = 1'b1;
          end
        end
        m_quiet = 0;
      end else if (m_st == P_MERGE) begin
        m_quiet++;
      end
      case (m_st)
        P_IDLE:  if (e_grnt) m_st = P_MERGE;
        P_MERGE: begin
          full = 1'b1;
          for (int i = 0; i < 64; i++) if (!m_mask[i]) full = 1'b0;
          drain = full || (st_req && st_addr[39:6] != m_line) || !wa_dis || sync ||
                  (q_old == TIMEOUT - 1);
          if (drain) m_st = P_AW;
        end
        P_AW: if (bus.bus_smg_aw_grnt) begin m_st = P_W; m_beat = 0; end
        P_W:  if (bus.bus_smg_w_rdy) begin
                if (m_beat == 3) m_st = P_B; else m_beat++;
              end
        P_B:  if (bus.bus_smg_b_vld) begin
                m_st = P_IDLE;
                for (int i = 0; i < 64; i++) m_mask[i] = 1'b0;
              end
        default: m_st = P_IDLE;
      endcase
    end
  end

  // ---------------- bus monitor ----------------
  always @(negedge clk) begin : monitor
    if (!rst_n) begin
      b_pending = 0; stall_left = 0; aw_prev = 0;
    end else begin
      if (bus.smg_bus_aw_req && !aw_prev) aw_cyc = cyc;
      aw_prev = bus.smg_bus_aw_req;
      if (bus.smg_bus_aw_req && bus.bus_smg_aw_grnt) begin
        got_aw.push_back(bus.smg_bus_aw_addr);
        resp_beat = 0;
      end
      if (bus.smg_bus_w_vld) wcyc++;
      if (bus.smg_bus_w_vld && bus.bus_smg_w_rdy) begin
        got_data.push_back(bus.smg_bus_w_data);
        got_strb.push_back(bus.smg_bus_w_strb);
        got_last.push_back(bus.smg_bus_w_last);
        resp_beat++;
        if (bus.smg_bus_w_last) b_pending = 1;
      end
      if (bus.bus_smg_b_vld && b_pending) begin
        b_pending = 0;
        bursts++;
      end
    end
  end

  // ---------------- bus responder ----------------
  initial begin : responder
    bus.bus_smg_aw_grnt = 1'b0; bus.bus_smg_w_rdy = 1'b0; bus.bus_smg_b_vld = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.bus_smg_aw_grnt = 1'b0; bus.bus_smg_w_rdy = 1'b0; bus.bus_smg_b_vld = 1'b0;
      if (bus.smg_bus_aw_req) begin
        aw_age++;
        bus.bus_smg_aw_grnt = (aw_age >= 2);
      end else aw_age = 0;
      if (bus.smg_bus_w_vld) begin
        if (resp_beat == stall_beat && stall_left > 0) stall_left--;
        else bus.bus_smg_w_rdy = 1'b1;
      end
      if (b_pending) begin
        b_age++;
        bus.bus_smg_b_vld = (b_age >= 2);
      end else b_age = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_caps();
    got_aw.delete(); got_data.delete(); got_strb.delete(); got_last.delete();
    exp_q.delete();
  endtask

  task automatic store(input logic [39:0] a, input logic [63:0] d, input logic [7:0] be,
                       input int max_tries, output bit g, output int tries);
    g = 0; tries = 0;
    st_req = 1'b1; st_addr = a; st_data = d; st_be = be;
    while (!g && tries < max_tries) begin
      @(negedge clk);
      g = grnt;
      tries++;
      if (g) last_grant_cyc = cyc;
      @(posedge clk); #1;
    end
    st_req = 1'b0;
  endtask

  task automatic store_ok(input logic [39:0] a, input logic [63:0] d, input logic [7:0] be);
    bit g; int t;
    store(a, d, be, 100, g, t);
    chk("store_granted", g, 1'b1);
  endtask

  task automatic wait_bursts(input int target);
    int n = 0;
    while (bursts < target && n < 2000) begin
      tick(1);
      n++;
    end
    chk("burst_complete", bursts >= target, 1'b1);
  endtask

  task automatic check_strbs(input string nm);
    logic [15:0] e;
    int i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(nm, (i < got_strb.size()) ? got_strb[i] : 16'hxxxx, e);
      i++;
    end
    chk({nm, "_count"}, got_strb.size(), 4);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : main
    bit g; int t, b0, mark, n;
    sync = 1'b0; wa_dis = 1'b1; st_req = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    @(negedge clk);
    chk("reset_idle_lit", idle, 1'b1);
    chk("reset_state_lit", dbg_state, 3'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // 1: eight full doublewords fill the line; drain the cycle after the last grant
    clear_caps(); b0 = bursts;
    for (int k = 0; k < 8; k++)
      store_ok(40'h80_0000_1000 + 40'(8 * k), 64'h0101_0101_0101_0101 * 64'(k + 1), 8'hFF);
    wait_bursts(b0 + 1);
    chk("t1_aw_gap", aw_cyc - last_grant_cyc, 1);
    chk("t1_aw_addr", awa(0), 40'h80_0000_1000);
    repeat (4) exp_q.push_back(16'hFFFF);
    check_strbs("t1_strb");
    chk("t1_last", {lst(3), lst(2), lst(1), lst(0)}, 4'b1000);
    chk("t1_beat0", dat(0), 128'h0202020202020202_0101010101010101);
    chk("t1_beat3", dat(3), 128'h0808080808080808_0707070707070707);

    // 2: lone partial store drains by timeout; offset 0x08 lands in bytes 8..11 of beat 0
    clear_caps(); b0 = bursts;
    store_ok(40'h80_0000_1048, 64'h0000_0000_1122_3344, 8'h0F);
    wait_bursts(b0 + 1);
    chk("t2_aw_gap", aw_cyc - last_grant_cyc, 17);
    chk("t2_aw_addr", awa(0), 40'h80_0000_1040);
    exp_q.push_back(16'h0F00); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    check_strbs("t2_strb");
    chk("t2_data", dat(0)[95:64], 32'h1122_3344);

    // 3: later store wins byte-wise
    clear_caps(); b0 = bursts;
    store_ok(40'h80_0000_2000, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF);
    store_ok(40'h80_0000_2000, 64'h0000_0000_0000_00EE, 8'h01);
    wait_bursts(b0 + 1);
    chk("t3_data", dat(0)[63:0], 64'hAAAA_BBBB_CCCC_DDEE);
    exp_q.push_back(16'h00FF); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    check_strbs("t3_strb");

    // 4: store to another line forces a drain and is retried until the buffer is idle
    clear_caps(); b0 = bursts;
    store_ok(40'h80_0000_3000, 64'h3333_3333_3333_3333, 8'hFF);
    store(40'h80_0000_3040, 64'h4444_4444_4444_4444, 8'hFF, 1, g, t);
    chk("t4_other_line_blocked", g, 1'b0);
    store(40'h80_0000_3040, 64'h4444_4444_4444_4444, 8'hFF, 200, g, t);
    chk("t4_retry_granted", g, 1'b1);
    chk("t4_drained_first", bursts - b0, 1);
    wait_bursts(b0 + 2);
    chk("t4_aw0", awa(0), 40'h80_0000_3000);
    chk("t4_aw1", awa(1), 40'h80_0000_3040);
    chk("t4_data1", dat(4)[63:0], 64'h4444_4444_4444_4444);

    // 5: ready held low three cycles on beat 1
    clear_caps(); b0 = bursts;
    stall_beat = 1; stall_left = 3;
    store_ok(40'h80_0000_4000, 64'h0F0E_0D0C_0B0A_0908, 8'hFF);
    wcyc = 0;
    wait_bursts(b0 + 1);
    chk("t5_beats", got_data.size(), 4);
    chk("t5_w_cycles", wcyc, 7);
    chk("t5_beat0", dat(0)[63:0], 64'h0F0E_0D0C_0B0A_0908);

    // 6: write-allocate re-enabled in MERGE; same-line store waits until idle
    clear_caps(); b0 = bursts;
    store_ok(40'h80_0000_5000, 64'h5555_5555_5555_5555, 8'hFF);
    tick(2);
    wa_dis = 1'b0;
    @(negedge clk); mark = cyc;
    @(posedge clk); #1;
    wa_dis = 1'b1;
    store(40'h80_0000_5008, 64'h6666_6666_6666_6666, 8'hFF, 100, g, t);
    chk("t6_granted_after_idle", g, 1'b1);
    chk("t6_drained_first", bursts - b0, 1);
    chk("t6_aw_gap", aw_cyc - mark, 1);
    wait_bursts(b0 + 2);
    chk("t6_aw1", awa(1), 40'h80_0000_5000);
    chk("t6_strb1", (got_strb.size() > 4) ? got_strb[4] : 16'hxxxx, 16'hFF00);

    // 7: sync held in IDLE blocks grants; sync in MERGE forces a drain
    sync = 1'b1;
    store(40'h80_0000_6000, 64'h7777_7777_7777_7777, 8'hFF, 5, g, t);
    chk("t7_sync_blocks", g, 1'b0);
    chk("t7_sync_idle", idle, 1'b1);
    sync = 1'b0;
    clear_caps(); b0 = bursts;
    store_ok(40'h80_0000_7000, 64'h8888_8888_8888_8888, 8'hFF);
    tick(1);
    sync = 1'b1;
    @(negedge clk); mark = cyc;
    @(posedge clk); #1;
    sync = 1'b0;
    wait_bursts(b0 + 1);
    chk("t7_aw_gap", aw_cyc - mark, 1);
    chk("t7_aw_addr", awa(0), 40'h80_0000_7000);

    // 8: reset in the middle of the data phase discards the line
    clear_caps(); b0 = bursts;
    stall_beat = 2; stall_left = 5;
    store_ok(40'h80_0000_8000, 64'h9999_9999_9999_9999, 8'hFF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.smg_bus_w_vld && n < 200);
    chk("t8_reached_w", bus.smg_bus_w_vld, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t8_rst_idle", idle, 1'b1);
    chk("t8_rst_w_vld", bus.smg_bus_w_vld, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("t8_no_response", bursts - b0, 0);
    chk("t8_still_idle", idle, 1'b1);
    clear_caps(); b0 = bursts;
    store_ok(40'h80_0000_9030, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    wait_bursts(b0 + 1);
    chk("t8_aw_addr", awa(0), 40'h80_0000_9000);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000); exp_q.push_back(16'h00FF);
    check_strbs("t8_strb");
    chk("t8_data3", dat(3)[63:0], 64'hDEAD_BEEF_0123_4567);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no completion by cycle %0d, want summary", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
